// File: rtl/packet_trace_feeder_pkg.sv
// Shared constants and types for the packet trace feeder.
// The config header word is the plain descriptor count N.
package packet_trace_feeder_pkg;
  localparam int TS_W_DEFAULT = 10;
  localparam int DESC_W = 32;
  localparam int CFG_W = 16;
  localparam int DESC_TIME_LSB = 0;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_LOAD,
    ST_RUN,
    ST_FWD
  } feeder_state_t;
endpackage

// File: rtl/packet_trace_feeder_ram.sv
// Descriptor store: synchronous write, combinational read.
// The combinational read keeps release latency at one cycle after eligibility.
module trace_desc_ram
  import packet_trace_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DESC_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/packet_trace_feeder.sv
// Loads a descriptor trace from the config chain, releases descriptors to the
// packet player by release time, and forwards config words not meant for this node.
module packet_trace_feeder
  import packet_trace_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = TS_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [TS_W-1:0]   sim_time,
  input  logic [CFG_W-1:0]  config_in,
  input  logic              config_in_valid,
  output logic [CFG_W-1:0]  config_out,
  output logic              config_out_valid,
  output logic [DESC_W-1:0] packet_out,
  output logic              packet_out_valid,
  input  logic              packet_request,
  output logic              is_quiescent,
  output logic              error,
  output logic [15:0]       issued_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CFG_W:0] DEPTH_CFG = (CFG_W + 1)'(DEPTH);

  feeder_state_t     state;
  logic [PW-1:0]     rd_ptr, wr_ptr, n_loaded;
  logic              half;
  logic [CFG_W-1:0]  lo_word;
  logic [DESC_W-1:0] head;
  logic [TS_W-1:0]   age;
  logic              issuing_state, pending, eligible, consume, wr_en, forward;

  assign issuing_state = (state == ST_RUN) || (state == ST_FWD);
  assign pending       = (rd_ptr != wr_ptr);
  // Wrap-safe: release time is not in the future when the modular age is in the lower half.
  assign age           = sim_time - head[DESC_TIME_LSB +: TS_W];
  assign eligible      = issuing_state && pending && !age[TS_W-1];
  assign consume       = packet_out_valid && packet_request && enable;
  assign wr_en         = (state == ST_LOAD) && config_in_valid && half;
  assign forward       = issuing_state && config_in_valid;
  assign is_quiescent  = (state != ST_LOAD) && !packet_out_valid && !pending;

  trace_desc_ram #(.DEPTH(DEPTH), .WIDTH(DESC_W)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({config_in, lo_word}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_HDR;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      n_loaded         <= '0;
      half             <= 1'b0;
      lo_word          <= '0;
      issued_count     <= '0;
      error            <= 1'b0;
      packet_out       <= '0;
      packet_out_valid <= 1'b0;
      config_out       <= '0;
      config_out_valid <= 1'b0;
    end else begin
      config_out_valid <= forward;
      if (forward) config_out <= config_in;

      case (state)
        ST_HDR: if (config_in_valid) begin
          // Header overflow is flagged even while stepping is disabled: loading runs regardless.
          if ({1'b0, config_in} > DEPTH_CFG) begin
            n_loaded <= PW'(DEPTH);
            error    <= 1'b1;
          end else begin
            n_loaded <= config_in[PW-1:0];
          end
          state <= (config_in == '0) ? ST_FWD : ST_LOAD;
        end
        ST_LOAD: if (config_in_valid) begin
          if (!half) begin
            lo_word <= config_in;
            half    <= 1'b1;
          end else begin
            half   <= 1'b0;
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr + 1'b1 == n_loaded) state <= ST_RUN;
          end
        end
        ST_RUN: if (consume && (rd_ptr + 1'b1 == wr_ptr)) state <= ST_FWD;
        default: ;
      endcase

      if (enable) begin
        if (consume) begin
          packet_out_valid <= 1'b0;
          rd_ptr           <= rd_ptr + 1'b1;
          issued_count     <= issued_count + 16'd1;
        end else if (!packet_out_valid && eligible) begin
          packet_out_valid <= 1'b1;
          packet_out       <= head;
        end
        if (packet_request && !packet_out_valid) error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_packet_trace_feeder.sv
// Scoreboard bench for packet_trace_feeder: directed traces, expected packets and
// forwarded config words are queued by the driver and popped by a negedge monitor.
module tb_packet_trace_feeder;
  import packet_trace_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int TS_W  = 10;

  logic              clock = 1'b0;
  logic              reset, enable, config_in_valid, packet_request;
  logic [TS_W-1:0]   sim_time;
  logic [CFG_W-1:0]  config_in, config_out;
  logic              config_out_valid, packet_out_valid, is_quiescent, error;
  logic [DESC_W-1:0] packet_out;
  logic [15:0]       issued_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] pkt_q[$];
  int          pkt_t_q[$];
  logic [15:0] cfg_q[$];
  int          cfg_t_q[$];

  logic [31:0] exp_pkt;
  int          exp_pkt_t;
  logic [15:0] exp_cfg;
  int          exp_cfg_t;

  packet_trace_feeder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .sim_time         (sim_time),
    .config_in        (config_in),
    .config_in_valid  (config_in_valid),
    .config_out       (config_out),
    .config_out_valid (config_out_valid),
    .packet_out       (packet_out),
    .packet_out_valid (packet_out_valid),
    .packet_request   (packet_request),
    .is_quiescent     (is_quiescent),
    .error            (error),
    .issued_count     (issued_count)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a packet or forwarded word.
  always @(negedge clock) begin
    if (!reset) begin
      if (packet_out_valid && packet_request && enable) begin
        if (pkt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pkt_unexpected: got %h expected none", packet_out);
        end else begin
          exp_pkt   = pkt_q.pop_front();
          exp_pkt_t = pkt_t_q.pop_front();
          check("pkt_data", packet_out, exp_pkt);
          if (exp_pkt_t >= 0) check("pkt_time", 32'(sim_time), 32'(exp_pkt_t));
        end
      end
      if (config_out_valid) begin
        if (cfg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg_unexpected: got %h expected none", config_out);
        end else begin
          exp_cfg   = cfg_q.pop_front();
          exp_cfg_t = cfg_t_q.pop_front();
          check("cfg_data", 32'(config_out), 32'(exp_cfg));
          check("cfg_cycle", 32'(cyc), 32'(exp_cfg_t));
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] w, input bit fwd);
    tick();
    config_in       = w;
    config_in_valid = 1'b1;
    if (fwd) begin
      cfg_q.push_back(w);
      cfg_t_q.push_back(cyc + 1);
    end
    tick();
    config_in_valid = 1'b0;
  endtask

  task automatic send_desc(input logic [31:0] d);
    send_cfg(d[15:0], 1'b0);
    send_cfg(d[31:16], 1'b0);
  endtask

  task automatic expect_pkt(input logic [31:0] d, input int t);
    pkt_q.push_back(d);
    pkt_t_q.push_back(t);
  endtask

  task automatic do_reset();
    packet_request = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clock);
    check("rst_valid", 32'(packet_out_valid), 32'd0);
    check("rst_cfg_valid", 32'(config_out_valid), 32'd0);
    check("rst_cfg_out", 32'(config_out), 32'd0);
    check("rst_quiescent", 32'(is_quiescent), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_issued", 32'(issued_count), 32'd0);
  endtask

  task automatic wait_issued(input int n, input int budget);
    int k = 0;
    while (issued_count != 16'(n) && k < budget) begin
      tick();
      k++;
    end
    check("issued_count", 32'(issued_count), 32'(n));
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    sim_time        = '0;
    config_in       = '0;
    config_in_valid = 1'b0;
    packet_request  = 1'b0;

    do_reset();
    check_reset_state();

    // Two descriptors released at sim_time 5 and 8; valid is seen one step later.
    send_cfg(16'd2, 1'b0);
    send_desc(32'h00AB_0005);
    send_desc(32'h00CD_0008);
    expect_pkt(32'h00AB_0005, 6);
    expect_pkt(32'h00CD_0008, 9);
    for (int t = 0; t < 16; t++) begin
      tick();
      sim_time       = TS_W'(t);
      packet_request = 1'b1;
    end
    wait_issued(2, 20);
    @(negedge clock);
    check("t1_quiescent", 32'(is_quiescent), 32'd1);

    // Overflowing header: 16 stored, last 8 data words forwarded.
    do_reset();
    sim_time = 10'd100;
    send_cfg(16'd20, 1'b0);
    @(negedge clock);
    check("ovf_error", 32'(error), 32'd1);
    for (int i = 0; i < 16; i++) begin
      send_desc({16'hD000 | 16'(i), 16'(i)});
      expect_pkt({16'hD000 | 16'(i), 16'(i)}, -1);
    end
    for (int k = 0; k < 8; k++) send_cfg(16'hF000 + 16'(k), 1'b1);
    @(negedge clock);
    check("ovf_valid_held", 32'(packet_out_valid), 32'd1);
    check("ovf_none_issued", 32'(issued_count), 32'd0);
    packet_request = 1'b1;
    wait_issued(16, 100);
    check("ovf_error_sticky", 32'(error), 32'd1);

    // Words after the trace are forwarded one cycle later.
    do_reset();
    send_cfg(16'd1, 1'b0);
    send_desc(32'h00EE_0003);
    expect_pkt(32'h00EE_0003, -1);
    send_cfg(16'h1234, 1'b1);
    send_cfg(16'h5678, 1'b1);
    packet_request = 1'b1;
    wait_issued(1, 20);

    // Release time 0x3FE across the sim_time wrap.
    do_reset();
    sim_time = 10'h3FC;
    send_cfg(16'd1, 1'b0);
    send_desc(32'h0077_03FE);
    tick(); sim_time = 10'h3FD;
    @(negedge clock);
    check("wrap_early_a", 32'(packet_out_valid), 32'd0);
    tick(); sim_time = 10'h3FE;
    @(negedge clock);
    check("wrap_early_b", 32'(packet_out_valid), 32'd0);
    tick(); sim_time = 10'h3FF;
    @(negedge clock);
    check("wrap_rise", 32'(packet_out_valid), 32'd1);
    tick(); sim_time = 10'h000;
    tick(); sim_time = 10'h001;
    @(negedge clock);
    check("wrap_hold", 32'(packet_out_valid), 32'd1);
    check("wrap_data", packet_out, 32'h0077_03FE);
    expect_pkt(32'h0077_03FE, 1);
    packet_request = 1'b1;
    wait_issued(1, 10);

    // Request without valid is a sticky error.
    do_reset();
    packet_request = 1'b1;
    tick();
    packet_request = 1'b0;
    @(negedge clock);
    check("req_no_valid", 32'(error), 32'd1);
    tick();
    tick();
    @(negedge clock);
    check("error_sticky", 32'(error), 32'd1);

    // enable=0 freezes release, issue and error; loading still works.
    do_reset();
    enable   = 1'b0;
    sim_time = 10'd10;
    send_cfg(16'd1, 1'b0);
    send_desc(32'h0044_0002);
    packet_request = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    check("en_freeze_valid", 32'(packet_out_valid), 32'd0);
    check("en_freeze_error", 32'(error), 32'd0);
    packet_request = 1'b0;
    enable = 1'b1;
    tick();
    @(negedge clock);
    check("en_release", 32'(packet_out_valid), 32'd1);
    enable = 1'b0;
    packet_request = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("en_freeze_issue", 32'(issued_count), 32'd0);
    check("en_freeze_hold", 32'(packet_out_valid), 32'd1);
    expect_pkt(32'h0044_0002, -1);
    enable = 1'b1;
    wait_issued(1, 10);

    // Reset mid-load discards the partial trace.
    do_reset();
    send_cfg(16'd4, 1'b0);
    send_cfg(16'h0001, 1'b0);
    send_cfg(16'h0011, 1'b0);
    send_cfg(16'h0002, 1'b0);
    do_reset();
    check_reset_state();
    sim_time = 10'd10;
    send_cfg(16'd1, 1'b0);
    send_desc(32'h0099_0001);
    expect_pkt(32'h0099_0001, -1);
    packet_request = 1'b1;
    wait_issued(1, 10);

    // Empty trace: quiescent immediately, following words forwarded.
    do_reset();
    send_cfg(16'd0, 1'b0);
    @(negedge clock);
    check("n0_quiescent", 32'(is_quiescent), 32'd1);
    send_cfg(16'hBEEF, 1'b1);
    repeat (3) tick();

    check("pkt_q_drained", 32'(pkt_q.size()), 32'd0);
    check("cfg_q_drained", 32'(cfg_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
